// File: rtl/ahb_sram_ws_ctrl_pkg.sv
// Shared types and helpers for the AHB-Lite to asynchronous SRAM bridge:
// bus-size encodings, FSM state encoding, access legality and byte-lane decode.
package ahb_sram_ws_ctrl_pkg;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    typedef enum logic [3:0] {
        SRAM_ST_IDLE,
        SRAM_ST_TURN,
        SRAM_ST_RD,
        SRAM_ST_RD_DONE,
        SRAM_ST_WR_SETUP,
        SRAM_ST_WR_PULSE,
        SRAM_ST_WR_HOLD,
        SRAM_ST_ERR1,
        SRAM_ST_ERR2
    } sram_state_t;

    function automatic logic access_legal(input logic [1:0] addr, input logic [2:0] size);
        case (size)
            HSIZE_BYTE: access_legal = 1'b1;
            HSIZE_HALF: access_legal = !addr[0];
            HSIZE_WORD: access_legal = (addr == 2'b00);
            default:    access_legal = 1'b0;
        endcase
    endfunction

    // Byte lane b lives on chip b>>1, upper byte when b is odd; reads use every lane.
    function automatic logic [3:0] lane_mask(input logic write, input logic [1:0] addr,
                                             input logic [2:0] size);
        if (!write) begin
            lane_mask = 4'hF;
        end else begin
            case (size)
                HSIZE_BYTE: lane_mask = 4'b0001 << addr;
                HSIZE_HALF: lane_mask = addr[1] ? 4'b1100 : 4'b0011;
                default:    lane_mask = 4'hF;
            endcase
        end
    endfunction

endpackage

// File: rtl/ahb_sram_ws_ctrl_dq_iobuf.sv
// Per-bit tri-state buffers for the SRAM data pins, one output enable per byte lane.
// Keeps the pad primitive out of the controller FSM.
module sram_dq_iobuf #(
    parameter int CHIPS = 3
) (
    input  logic [16*CHIPS-1:0] dq_o,
    input  logic [2*CHIPS-1:0]  dq_oe,
    output logic [16*CHIPS-1:0] dq_i,
    inout  wire  [16*CHIPS-1:0] SRAM_DATA
);

    for (genvar i = 0; i < 16*CHIPS; i++) begin : g_bit
        assign SRAM_DATA[i] = dq_oe[i/8] ? dq_o[i] : 1'bz;
    end

    assign dq_i = SRAM_DATA;

endmodule

// File: rtl/ahb_sram_ws_ctrl.sv
// AHB-Lite slave for external asynchronous 16-bit SRAM chips with programmable
// read/write wait states, registered read data, write setup/pulse/hold and ERROR responses.
module ahb_sram_ws_ctrl
    import ahb_sram_ws_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 20,
    parameter int CHIPS   = 3,
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 2
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSEL,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    input  logic [2:0]        HSIZE,
    input  logic              HWRITE,
    input  logic              HREADY,
    input  logic [31:0]       HWDATA,
    output logic [31:0]       HRDATA,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic [CHIPS-1:0]  SRAM_CE_N,
    output logic [CHIPS-1:0]  SRAM_OE_N,
    output logic [CHIPS-1:0]  SRAM_WE_N,
    output logic [CHIPS-1:0]  SRAM_UB_N,
    output logic [CHIPS-1:0]  SRAM_LB_N,
    inout  wire  [16*CHIPS-1:0] SRAM_DATA
);

    localparam int         DQ_W    = 16*CHIPS;
    localparam int         LANES   = 2*CHIPS;
    localparam logic [3:0] RD_LOAD = 4'(RD_WAIT);
    localparam logic [3:0] WR_LOAD = 4'(WR_WAIT);

    sram_state_t       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [3:0]        lanes_q, lanes_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CHIPS-1:0]  ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
    logic [CHIPS-1:0]  ub_n_q, ub_n_d, lb_n_q, lb_n_d;
    logic [LANES-1:0]  dq_oe_q, dq_oe_d;
    logic [DQ_W-1:0]   dq_o, dq_i;
    logic              accept, active;
    logic              unused_ok;

    assign HREADYOUT = !(state_q inside {SRAM_ST_TURN, SRAM_ST_RD, SRAM_ST_WR_SETUP,
                                         SRAM_ST_WR_PULSE, SRAM_ST_ERR1});
    assign HRESP     = (state_q inside {SRAM_ST_ERR1, SRAM_ST_ERR2});
    assign accept    = HSEL & HREADY & HTRANS[1] & HREADYOUT;
    assign unused_ok = ^{HADDR[31:ADDR_W+2], HTRANS[0], dq_i[DQ_W-1:32]};

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
        lanes_d = lanes_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        wdata_d = wdata_q;
        case (state_q)
            SRAM_ST_TURN: begin
                state_d = SRAM_ST_RD;
                cnt_d   = RD_LOAD;
            end
            SRAM_ST_RD: begin
                if (cnt_q == 4'd0) begin
                    state_d = SRAM_ST_RD_DONE;
                    rdata_d = dq_i[31:0];
                end
            end
            SRAM_ST_WR_SETUP: begin
                state_d = SRAM_ST_WR_PULSE;
                cnt_d   = WR_LOAD;
                wdata_d = HWDATA;
            end
            SRAM_ST_WR_PULSE: if (cnt_q == 4'd0) state_d = SRAM_ST_WR_HOLD;
            SRAM_ST_ERR1:     state_d = SRAM_ST_ERR2;
            default:          state_d = SRAM_ST_IDLE;
        endcase
        // Accepts only happen in HREADYOUT=1 states, so they chain straight into the next access.
        if (accept) begin
            addr_d  = HADDR[ADDR_W+1:2];
            lanes_d = lane_mask(HWRITE, HADDR[1:0], HSIZE);
            if (!access_legal(HADDR[1:0], HSIZE)) begin
                state_d = SRAM_ST_ERR1;
            end else if (HWRITE) begin
                state_d = SRAM_ST_WR_SETUP;
            end else if (state_q == SRAM_ST_WR_HOLD) begin
                state_d = SRAM_ST_TURN;
            end else begin
                state_d = SRAM_ST_RD;
                cnt_d   = RD_LOAD;
            end
        end
    end

    // Pin controls are registered from the next state so they are glitch-free and
    // OE (RD only) can never overlap DQ drive (WR_PULSE/WR_HOLD only).
    always_comb begin
        ce_n_d  = '1;
        oe_n_d  = '1;
        we_n_d  = '1;
        ub_n_d  = '1;
        lb_n_d  = '1;
        dq_oe_d = '0;
        active  = (state_d inside {SRAM_ST_TURN, SRAM_ST_RD, SRAM_ST_WR_SETUP,
                                   SRAM_ST_WR_PULSE, SRAM_ST_WR_HOLD});
        for (int k = 0; k < 2; k++) begin
            ce_n_d[k] = !active;
            oe_n_d[k] = !(state_d == SRAM_ST_RD);
            ub_n_d[k] = !(active && lanes_d[2*k+1]);
            lb_n_d[k] = !(active && lanes_d[2*k]);
            we_n_d[k] = !((state_d == SRAM_ST_WR_PULSE) && (lanes_d[2*k] || lanes_d[2*k+1]));
        end
        if (state_d inside {SRAM_ST_WR_PULSE, SRAM_ST_WR_HOLD}) dq_oe_d[3:0] = lanes_d;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= SRAM_ST_IDLE;
            cnt_q   <= '0;
            lanes_q <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
            wdata_q <= '0;
            ce_n_q  <= '1;
            oe_n_q  <= '1;
            we_n_q  <= '1;
            ub_n_q  <= '1;
            lb_n_q  <= '1;
            dq_oe_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lanes_q <= lanes_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            wdata_q <= wdata_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            ub_n_q  <= ub_n_d;
            lb_n_q  <= lb_n_d;
            dq_oe_q <= dq_oe_d;
        end
    end

    assign HRDATA    = rdata_q;
    assign SRAM_ADDR = addr_q;
    assign SRAM_CE_N = ce_n_q;
    assign SRAM_OE_N = oe_n_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_UB_N = ub_n_q;
    assign SRAM_LB_N = lb_n_q;
    assign dq_o      = DQ_W'(wdata_q);

    sram_dq_iobuf #(.CHIPS(CHIPS)) u_iobuf (
        .dq_o      (dq_o),
        .dq_oe     (dq_oe_q),
        .dq_i      (dq_i),
        .SRAM_DATA (SRAM_DATA)
    );

endmodule

// File: tb/tb_ahb_sram_ws_ctrl.sv
// Scoreboard bench for ahb_sram_ws_ctrl: directed AHB transfers against a small
// behavioural model of two 16-bit SRAM chips.
module tb_ahb_sram_ws_ctrl;

    logic        HCLK, HRESET, HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [19:0] sram_addr;
    logic [2:0]  ce_n, oe_n, we_n, ub_n, lb_n;
    wire  [47:0] sram_data;

    assign HREADY = HREADYOUT;

    ahb_sram_ws_ctrl #(.ADDR_W(20), .CHIPS(3), .RD_WAIT(2), .WR_WAIT(2)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
        .SRAM_ADDR(sram_addr), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n),
        .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_DATA(sram_data)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    // SRAM model: chips 0 and 1 hold the 32-bit word, 16 words deep.
    logic [31:0] mem [0:15];
    logic        init_done = 1'b0;

    for (genvar k = 0; k < 2; k++) begin : g_chip
        assign sram_data[16*k +: 16] = (!ce_n[k] && !oe_n[k]) ? mem[sram_addr[3:0]][16*k +: 16]
                                                              : 16'hzzzz;
    end

    always @(posedge HCLK) begin
        if (!init_done) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[0]    <= 32'h1122_3344;
            mem[1]    <= 32'h9988_7766;
            mem[4]    <= 32'hDEAD_BEEF;
            init_done <= 1'b1;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (!ce_n[k] && !we_n[k]) begin
                    if (!lb_n[k]) mem[sram_addr[3:0]][16*k +: 8]   <= sram_data[16*k +: 8];
                    if (!ub_n[k]) mem[sram_addr[3:0]][16*k+8 +: 8] <= sram_data[16*k+8 +: 8];
                end
            end
        end
    end

    typedef struct {
        logic        wr;
        logic [31:0] rdata;
        logic        resp;
        int          waits;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic pend    = 1'b0;
    int   wcnt    = 0;
    int   inv_bad = 0;
    int   c2_bad  = 0;
    int   we0_cnt = 0, we1_cnt = 0, we_any_cnt = 0;
    logic [3:0] we1_lanes = 4'h0;
    logic [7:0] we1_byte  = 8'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Response monitor: a data phase ends on the first HREADYOUT=1 cycle after acceptance.
    always @(negedge HCLK) begin
        if (HRESET) begin
            pend <= 1'b0;
            wcnt <= 0;
            sbq.delete();
        end else begin
            if (pend && HREADYOUT) begin
                if (sbq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_underflow: response seen with empty queue");
                end else begin
                    mon_e = sbq.pop_front();
                    chk("hresp", {63'd0, HRESP}, {63'd0, mon_e.resp});
                    chk("wait_cycles", 64'(wcnt), 64'(mon_e.waits));
                    if (!mon_e.wr && !mon_e.resp) chk("hrdata", {32'd0, HRDATA}, {32'd0, mon_e.rdata});
                end
            end
            wcnt <= (pend && !HREADYOUT) ? wcnt + 1 : 0;
            pend <= (pend && !HREADYOUT) || (HREADYOUT && HSEL && HTRANS[1]);
        end
    end

    always @(negedge HCLK) begin
        if (!HRESET) begin
            for (int k = 0; k < 2; k++)
                if (!oe_n[k] && (dut.dq_oe_q[2*k +: 2] != 2'b00)) inv_bad <= inv_bad + 1;
            if ({ce_n[2], oe_n[2], we_n[2], ub_n[2], lb_n[2]} != 5'h1F) c2_bad <= c2_bad + 1;
            if (!we_n[0]) we0_cnt <= we0_cnt + 1;
            if (we_n[1:0] != 2'b11) we_any_cnt <= we_any_cnt + 1;
            if (!we_n[1]) begin
                we1_cnt   <= we1_cnt + 1;
                we1_lanes <= {~ub_n[1], ~lb_n[1], ~ub_n[0], ~lb_n[0]};
                we1_byte  <= sram_data[31:24];
            end
        end
    end

    task automatic xfer(input logic track, input logic wr, input logic [31:0] addr,
                        input logic [2:0] size, input logic [31:0] wdata,
                        input logic [31:0] rdata, input logic resp, input int waits);
        exp_t e;
        int   t;
        e.wr = wr; e.rdata = rdata; e.resp = resp; e.waits = waits;
        if (track) sbq.push_back(e);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HSIZE = size; HWRITE = wr;
        t = 0;
        @(negedge HCLK);
        while (!HREADYOUT && t < 100) begin
            @(negedge HCLK);
            t++;
        end
        if (!HREADYOUT) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: HREADYOUT=%0b, expected 1 within 100 cycles", HREADYOUT);
        end
        @(posedge HCLK);
        #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wdata;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sbq.size() != 0 || pend) && t < 200) begin
            @(negedge HCLK);
            t++;
        end
        if (sbq.size() != 0 || pend) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sbq.size());
        end
        @(posedge HCLK);
        #1;
    endtask

    int base0, base1, base_any, t;

    initial begin
        HRESET = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HADDR = '0; HSIZE = 3'd2;
        HWRITE = 1'b0; HWDATA = '0;
        repeat (3) @(posedge HCLK);
        #1;
        chk("rst_hreadyout", {63'd0, HREADYOUT}, 64'd1);
        chk("rst_hresp",     {63'd0, HRESP},     64'd0);
        chk("rst_hrdata",    {32'd0, HRDATA},    64'd0);
        chk("rst_ctrl_n",    {49'd0, ce_n, oe_n, we_n, ub_n, lb_n}, 64'h7FFF);
        chk("rst_addr",      {44'd0, sram_addr}, 64'd0);
        chk("rst_dq_oe",     {58'd0, dut.dq_oe_q}, 64'd0);
        HRESET = 1'b0;
        @(posedge HCLK);
        #1;

        // Word read, 3 stall cycles.
        xfer(1'b1, 1'b0, 32'h0000_0010, 3'd2, 32'h0, 32'hDEAD_BEEF, 1'b0, 3);
        chk("rd_sram_addr", {44'd0, sram_addr}, 64'd4);
        chk("rd_oe_n",      {61'd0, oe_n},      64'h4);
        drain();

        // Byte write to lane 3.
        base0 = we0_cnt; base1 = we1_cnt;
        xfer(1'b1, 1'b1, 32'h0000_0003, 3'd0, 32'hAB00_0000, 32'h0, 1'b0, 4);
        drain();
        chk("bw_we1_cycles", 64'(we1_cnt - base1), 64'd3);
        chk("bw_we0_cycles", 64'(we0_cnt - base0), 64'd0);
        chk("bw_lanes",      {60'd0, we1_lanes},   64'h8);
        chk("bw_dq_byte",    {56'd0, we1_byte},    64'hAB);
        xfer(1'b1, 1'b0, 32'h0000_0000, 3'd2, 32'h0, 32'hAB22_3344, 1'b0, 3);
        drain();

        // Upper halfword write, read back.
        xfer(1'b1, 1'b1, 32'h0000_0006, 3'd1, 32'h1234_0000, 32'h0, 1'b0, 4);
        drain();
        xfer(1'b1, 1'b0, 32'h0000_0004, 3'd2, 32'h0, 32'h1234_7766, 1'b0, 3);
        drain();

        // Back-to-back write then read of the same word: TURN adds one stall.
        xfer(1'b1, 1'b1, 32'h0000_0020, 3'd2, 32'hCAFE_F00D, 32'h0, 1'b0, 4);
        xfer(1'b1, 1'b0, 32'h0000_0020, 3'd2, 32'h0, 32'hCAFE_F00D, 1'b0, 4);
        drain();
        xfer(1'b1, 1'b0, 32'h0000_0012, 3'd1, 32'h0, 32'hDEAD_BEEF, 1'b0, 3);
        drain();

        // Illegal accesses: two-cycle ERROR, no write strobe.
        base_any = we_any_cnt;
        xfer(1'b1, 1'b1, 32'h0000_0001, 3'd1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1);
        drain();
        xfer(1'b1, 1'b1, 32'h0000_0000, 3'd3, 32'hFFFF_FFFF, 32'h0, 1'b1, 1);
        drain();
        xfer(1'b1, 1'b0, 32'h0000_0002, 3'd2, 32'h0, 32'h0, 1'b1, 1);
        drain();
        chk("err_no_we", 64'(we_any_cnt - base_any), 64'd0);

        // Reset during the write pulse.
        xfer(1'b0, 1'b1, 32'h0000_0008, 3'd2, 32'h55AA_55AA, 32'h0, 1'b0, 0);
        t = 0;
        @(negedge HCLK);
        while (we_n[0] && t < 50) begin
            @(negedge HCLK);
            t++;
        end
        chk("mid_we_low", {63'd0, we_n[0]}, 64'd0);
        HRESET = 1'b1;
        #1;
        chk("mid_rst_we_n",  {61'd0, we_n},         64'h7);
        chk("mid_rst_dq_oe", {58'd0, dut.dq_oe_q},  64'd0);
        chk("mid_rst_ready", {63'd0, HREADYOUT},    64'd1);
        repeat (2) @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        @(posedge HCLK);
        #1;
        xfer(1'b1, 1'b0, 32'h0000_0010, 3'd2, 32'h0, 32'hDEAD_BEEF, 1'b0, 3);
        drain();

        chk("oe_dq_overlap", 64'(inv_bad), 64'd0);
        chk("chip2_idle",    64'(c2_bad),  64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
